pixel_feeder: RTL and testbench

- Transmit-side partner of the 3x3 line-buffer window controller.
- Reads an 8-bit greyscale image from a source memory with fixed 1-cycle read latency and streams it one pixel per cycle into the controller's i_pixel_data/i_pixel_data_valid inputs.
- Flow control is line-granular credits: PRIME_LINES credits at start, plus one credit back per controller line-done interrupt. This ensures a line buffer is never overwritten before it has been read.

---
 rtl/img_pkg.sv | 22 ++
 rtl/feeder_credit_ctr.sv | 41 ++++
 rtl/pixel_feeder.sv | 218 +++++++++++++++++++++
 tb/tb_pixel_feeder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image constants and the pixel_feeder FSM state type.
// Default frame geometry is common to the feeder and the 3x3 window controller.
package img_pkg;

    localparam int PIXEL_W         = 8;
    localparam int DEF_LINE_WIDTH  = 512;
    localparam int DEF_NUM_LINES   = 512;
    localparam int DEF_PRIME_LINES = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_CREDIT = 2'd1,
        SEND_LINE   = 2'd2,
        DRAIN       = 2'd3
    } feeder_state_e;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feeder_credit_ctr.sv
// Line credit counter for pixel_feeder.
// Saturates at MAX_CREDITS; a simultaneous return and consume leaves the count
// unchanged, and the returning credit can be spent in the same cycle.
module feeder_credit_ctr
    import img_pkg::*;
#(
    parameter int MAX_CREDITS = DEF_PRIME_LINES,
    parameter int CNT_W       = cnt_w(DEF_PRIME_LINES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    input  logic inc,
    input  logic dec,
    output logic has_credit
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CREDITS);

    logic [CNT_W-1:0] count;

    // Credit count: reload on frame start, otherwise saturating up/down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= MAX_C;
        end else if (init) begin
            count <= MAX_C;
        end else if (inc && !dec) begin
            if (count != MAX_C) begin
                count <= count + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign has_credit = (count != '0) || inc;

endmodule

// File: rtl/pixel_feeder.sv
// pixel_feeder: streams an 8-bit image from a 1-cycle-latency source memory
// into the line-buffer window controller, one line per credit.
// Optional build macro PIXEL_FEEDER_PAD_EN adds an all-zero line before and
// after the frame (NUM_LINES+2 lines, pad lines issue no memory reads).
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for i_start
// WAIT_CREDIT | frame active, no downstream line buffer free yet
// SEND_LINE   | issuing one read (or pad slot) per cycle for the line
// DRAIN       | two cycles for the read/register pipeline to empty
module pixel_feeder
    import img_pkg::*;
#(
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int PRIME_LINES = DEF_PRIME_LINES,
    parameter int ADDR_W      = 18
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_base_addr,
    output logic               o_mem_rd,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic [PIXEL_W-1:0] i_mem_rdata,
    output logic [PIXEL_W-1:0] o_pixel_data,
    output logic               o_pixel_data_valid,
    input  logic               i_intr,
    output logic               o_busy,
    output logic               o_done
);

`ifdef PIXEL_FEEDER_PAD_EN
    localparam int TOTAL_LINES = NUM_LINES + 2;
`else
    localparam int TOTAL_LINES = NUM_LINES;
`endif
    localparam int COL_W  = cnt_w(LINE_WIDTH);
    localparam int LINE_W = cnt_w(NUM_LINES + 2);
    localparam int CRED_W = cnt_w(PRIME_LINES + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(TOTAL_LINES - 1);

    feeder_state_e state;
    feeder_state_e state_nx;

    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] addr;
    logic              drain_cnt;
    logic              busy;
    logic              done;
    logic              vld_d1;

    logic start_acc;
    logic take_credit;
    logic send;
    logic last_col;
    logic last_line;
    logic done_nx;
    logic has_credit;

    assign last_line = (line == LINE_LAST);

`ifdef PIXEL_FEEDER_PAD_EN
    logic pad_line;
    logic pad_d1;

    assign pad_line = (line == '0) || last_line;
    assign o_mem_rd = send && !pad_line;
`else
    assign o_mem_rd = send;
`endif

    assign o_mem_addr = addr;
    assign o_busy     = busy;
    assign o_done     = done;

    feeder_credit_ctr #(
        .MAX_CREDITS (PRIME_LINES),
        .CNT_W       (CRED_W)
    ) u_credit (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .init       (start_acc),
        .inc        (i_intr),
        .dec        (take_credit),
        .has_credit (has_credit)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus the per-cycle control strobes that drive the datapath.
    always_comb begin
        state_nx    = state;
        start_acc   = 1'b0;
        take_credit = 1'b0;
        send        = 1'b0;
        last_col    = 1'b0;
        done_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_nx  = WAIT_CREDIT;
                end
            end
            WAIT_CREDIT: begin
                if (has_credit) begin
                    take_credit = 1'b1;
                    state_nx    = SEND_LINE;
                end
            end
            SEND_LINE: begin
                send = 1'b1;
                if (col == COL_LAST) begin
                    last_col = 1'b1;
                    if (last_line) begin
                        state_nx = DRAIN;
                    end else if (has_credit) begin
                        // Back-to-back line: stay in SEND_LINE, no bubble.
                        take_credit = 1'b1;
                    end else begin
                        state_nx = WAIT_CREDIT;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Frame counters, running read address and busy/done flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr      <= '0;
            line      <= '0;
            col       <= '0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_nx;

            if (start_acc) begin
                addr <= i_base_addr;
                line <= '0;
                col  <= '0;
                busy <= 1'b1;
            end else if (done_nx) begin
                busy <= 1'b0;
            end

            if (send) begin
                if (last_col) begin
                    col <= '0;
                    if (!last_line) begin
                        line <= line + LINE_W'(1);
                    end
                end else begin
                    col <= col + COL_W'(1);
                end
                // Pad slots do not read, so the address only moves on real reads.
                if (o_mem_rd) begin
                    addr <= addr + ADDR_W'(1);
                end
            end

            if (state == DRAIN) begin
                drain_cnt <= ~drain_cnt;
            end else begin
                drain_cnt <= 1'b0;
            end
        end
    end

    // Two-stage pixel pipe: memory read, then register the returned data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_d1             <= 1'b0;
            o_pixel_data_valid <= 1'b0;
            o_pixel_data       <= '0;
`ifdef PIXEL_FEEDER_PAD_EN
            pad_d1             <= 1'b0;
`endif
        end else begin
            vld_d1             <= send;
            o_pixel_data_valid <= vld_d1;
`ifdef PIXEL_FEEDER_PAD_EN
            pad_d1 <= send && pad_line;
            if (vld_d1) begin
                o_pixel_data <= pad_d1 ? '0 : i_mem_rdata;
            end
`else
            if (vld_d1) begin
                o_pixel_data <= i_mem_rdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pixel_feeder.sv
// Self-checking bench for pixel_feeder on a reduced 16x8 frame.
// Honours PIXEL_FEEDER_PAD_EN when defined for both bench and design.
module tb_pixel_feeder;

    localparam int LW = 16;
    localparam int NL = 8;
    localparam int PR = 4;
    localparam int AW = 10;
`ifdef PIXEL_FEEDER_PAD_EN
    localparam bit PAD = 1'b1;
    localparam int NLT = NL + 2;
`else
    localparam bit PAD = 1'b0;
    localparam int NLT = NL;
`endif
    localparam int FRAME_PIX  = NLT * LW;
    localparam int INTR_DELAY = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    pix;
    logic          pix_vld;
    logic          intr_manual = 1'b0;
    logic          intr_model = 1'b0;
    logic          intr;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int rd_cnt   = 0;
    int vld_cnt  = 0;
    bit model_en = 1'b0;

    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_pix_q[$];

    assign intr = intr_manual | intr_model;

    pixel_feeder #(
        .LINE_WIDTH  (LW),
        .NUM_LINES   (NL),
        .PRIME_LINES (PR),
        .ADDR_W      (AW)
    ) u_dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_start            (start),
        .i_base_addr        (base_addr),
        .o_mem_rd           (mem_rd),
        .o_mem_addr         (mem_addr),
        .i_mem_rdata        (mem_rdata),
        .o_pixel_data       (pix),
        .o_pixel_data_valid (pix_vld),
        .i_intr             (intr),
        .o_busy             (busy),
        .o_done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
        return a[7:0] + 8'd37 * {6'd0, a[9:8]};
    endfunction

    // Source memory: one cycle read latency, junk when not reading.
    always @(posedge clk) mem_rdata <= mem_rd ? mem_val(mem_addr) : 8'hEE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Queue expected reads and pixels for the first n slots of a frame.
    task automatic push_exp(input logic [AW-1:0] b, input int n_pix, input int n_rd);
        int n = (n_pix > n_rd) ? n_pix : n_rd;
        for (int s = 0; s < n; s++) begin
            int ln = s / LW;
            int cl = s % LW;
            bit is_pad = PAD && (ln == 0 || ln == NLT - 1);
            logic [AW-1:0] a = b + AW'((ln - (PAD ? 1 : 0)) * LW + cl);
            if (s < n_pix) exp_pix_q.push_back(is_pad ? 8'h00 : mem_val(a));
            if (s < n_rd && !is_pad) exp_addr_q.push_back(a);
        end
    endtask

    // Scoreboard monitor.
    initial begin
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_rd) begin
                    rd_cnt++;
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mem_rd_unexpected: read of 0x%0h with none required", mem_addr);
                    end else begin
                        check("mem_addr", mem_addr, exp_addr_q.pop_front());
                    end
                end
                if (pix_vld) begin
                    vld_cnt++;
                    if (exp_pix_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL pixel_unexpected: pixel 0x%0h with none required", pix);
                    end else begin
                        check("pixel_data", pix, exp_pix_q.pop_front());
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("busy_low_at_done", busy, 0);
                end
                if (busy_prev && !busy) check("busy_falls_with_done", done, 1);
            end
            busy_prev = busy;
        end
    end

    // Downstream model: returns a credit INTR_DELAY cycles after each line.
    initial begin
        int line_pix;
        int pending[$];
        line_pix = 0;
        forever begin
            @(negedge clk);
            intr_model = 1'b0;
            if (!model_en) begin
                line_pix = 0;
                pending.delete();
            end else begin
                if (pix_vld) begin
                    line_pix++;
                    if (line_pix == LW) begin
                        line_pix = 0;
                        pending.push_back(cyc + INTR_DELAY);
                    end
                end
                if (pending.size() > 0 && pending[0] <= cyc) begin
                    void'(pending.pop_front());
                    intr_model = 1'b1;
                end
            end
        end
    end

    task automatic pulse_start(input logic [AW-1:0] b);
        @(negedge clk);
        base_addr = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Call at a negedge: i_intr high for the following posedge only.
    task automatic pulse_intr();
        intr_manual = 1'b1;
        fork
            begin
                @(negedge clk);
                intr_manual = 1'b0;
            end
        join_none
    endtask

    task automatic collect(input string name, input int n, input int budget, input bit contig,
                           output int first_c, output int last_c);
        int got = 0;
        int waited = 0;
        first_c = -1;
        last_c = -1;
        while (got < n && waited < budget) begin
            @(negedge clk);
            waited++;
            if (pix_vld) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                got++;
            end
        end
        check({name, "_count"}, got, n);
        if (contig) check({name, "_no_bubble"}, last_c - first_c + 1, n);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int rd = 0;
        int vl = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (mem_rd) rd++;
            if (pix_vld) vl++;
        end
        check({name, "_rd_quiet"}, rd, 0);
        check({name, "_vld_quiet"}, vl, 0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int waited = 0;
        while (done_cnt == d0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        check({name, "_done_once"}, done_cnt - d0, 1);
        check({name, "_busy_low"}, busy, 0);
        check({name, "_sb_empty"}, exp_pix_q.size() + exp_addr_q.size(), 0);
    endtask

    task automatic finish_manual(input string name, input int lines);
        int f;
        int l;
        for (int i = 0; i < lines; i++) begin
            @(negedge clk);
            pulse_intr();
            collect({name, "_line"}, LW, 100, 1'b1, f, l);
        end
        wait_done(name, 100);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_mem_rd"}, mem_rd, 0);
        check({name, "_mem_addr"}, mem_addr, 0);
        check({name, "_pixel"}, pix, 0);
        check({name, "_valid"}, pix_vld, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int l;
        int f2;
        int l2;
        int rd0;
        int v0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Frame 1: priming, single and double credit return, wrap at top of memory.
        push_exp(10'h3F0, FRAME_PIX, FRAME_PIX);
        pulse_start(10'h3F0);
        check("f1_busy", busy, 1);
        collect("prime", 4 * LW, 200, 1'b1, f, l);
        expect_quiet("prime", 40);
        check("prime_busy_held", busy, 1);
        @(negedge clk);
        pulse_intr();
        collect("credit1", LW, 100, 1'b1, f, l);
        expect_quiet("credit1", 30);
        @(negedge clk);
        fork
            begin
                pulse_intr();
                repeat (10) @(negedge clk);
                pulse_intr();
            end
        join_none
        collect("credit2", 2 * LW, 200, 1'b1, f, l);
        expect_quiet("credit2", 20);
        finish_manual("f1", NLT - 7);

        // Frame 2: credit returned on the last column while at zero credits.
        push_exp(10'h055, FRAME_PIX, FRAME_PIX);
        pulse_start(10'h055);
        collect("simul_a", 4 * LW - 2, 200, 1'b1, f, l);
        pulse_intr();
        collect("simul_b", LW + 2, 100, 1'b1, f2, l2);
        check("simul_no_gap", l2 - f + 1, 5 * LW);
        expect_quiet("simul", 40);
        check("simul_credits", u_dut.u_credit.count, 0);
        finish_manual("f2", NLT - 5);

        // Frame 3: full frame with a delayed-credit downstream, start ignored mid-frame.
        rd0 = rd_cnt;
        v0 = vld_cnt;
        model_en = 1'b1;
        push_exp(10'h200, FRAME_PIX, FRAME_PIX);
        pulse_start(10'h200);
        collect("full_a", 3 * LW, 200, 1'b0, f, l);
        fork
            pulse_start(10'h000);
        join_none
        collect("full_b", FRAME_PIX - 3 * LW, NLT * (LW + INTR_DELAY + 20), 1'b0, f, l);
        wait_done("full", 100);
        check("full_rd_count", rd_cnt - rd0, NL * LW);
        check("full_vld_count", vld_cnt - v0, FRAME_PIX);
        repeat (INTR_DELAY + 10) @(negedge clk);
        model_en = 1'b0;

        // Frame 4: reset during frame line 2 column 10, then restart.
        push_exp(10'h123, 2 * LW + 9, 2 * LW + 11);
        pulse_start(10'h123);
        collect("rst_a", 2 * LW + 9, 200, 1'b1, f, l);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        check("rst_sb_empty", exp_pix_q.size() + exp_addr_q.size(), 0);
        repeat (4) @(negedge clk);
        check("rst_hold_valid", pix_vld, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_idle_busy", busy, 0);
        check("rst_release_idle_rd", mem_rd, 0);
        push_exp(10'h123, FRAME_PIX, FRAME_PIX);
        pulse_start(10'h123);
        collect("restart_prime", 4 * LW, 200, 1'b1, f, l);
        expect_quiet("restart", 30);
        finish_manual("f4", NLT - 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
